// File: rtl/data_mem_pkg.sv
// Shared widths and word/address types for the KGP-RISC data memory.
package data_mem_pkg;

  localparam int DM_ADDR_WIDTH = 10;
  localparam int DM_DATA_WIDTH = 32;
  localparam int DM_DEPTH      = 1 << DM_ADDR_WIDTH;

  typedef logic [DM_DATA_WIDTH-1:0] dm_word_t;
  typedef logic [DM_ADDR_WIDTH-1:0] dm_addr_t;

endpackage : data_mem_pkg

// File: rtl/data_mem_array.sv
// Zero-initialised storage array: synchronous write, combinational read.
// No reset on the storage, so the surrounding register maps it onto block RAM.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int Depth = 1 << ADDR_WIDTH;

  // Power-up contents are all zero; reset never touches them.
  logic [DATA_WIDTH-1:0] mem_q [Depth] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule : data_mem_array

// File: rtl/data_mem.sv
// Single-port 1024x32 data memory with write-first registered output.
// Only the output register is reset; reset also blocks writes into the array.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DM_DATA_WIDTH
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic [0:0]            wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta
);

  logic                  we;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] douta_d;
  logic [DATA_WIDTH-1:0] douta_q;

  // An unknown wea resolves to no write in both the array and the mux.
  assign we = wea[0] & rsta;

  data_mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk     (clka),
    .we_i    (we),
    .addr_i  (addra),
    .wdata_i (dina),
    .rdata_o (rd_data)
  );

  always_comb begin
    douta_d = rd_data;
    if (wea[0]) begin
      douta_d = dina;
    end
  end

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      douta_q <= '0;
    end else begin
      douta_q <= douta_d;
    end
  end

  assign douta = douta_q;

endmodule : data_mem

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed test plan plus randomized
// reads/writes against a plain array model of the memory.
module tb_data_mem;
  import data_mem_pkg::*;

  logic     clka;
  logic     rsta;
  logic [0:0] wea;
  dm_addr_t addra;
  dm_word_t dina;
  dm_word_t douta;

  int checks;
  int errors;

  // Reference model: contents as words, zero at power-up.
  dm_word_t model_mem [DM_DEPTH];

  data_mem dut (
    .clka  (clka),
    .rsta  (rsta),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .douta (douta)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic check_val(input string tag, input dm_word_t got, input dm_word_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: douta=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // One clocked transaction with reset released; checks douta after the edge.
  task automatic do_op(input string tag, input logic we, input dm_addr_t a, input dm_word_t d);
    dm_word_t exp;
    @(negedge clka);
    wea   = we;
    addra = a;
    dina  = d;
    @(posedge clka);
    #1;
    if (we) begin
      model_mem[a] = d;
      exp = d;
    end else begin
      exp = model_mem[a];
    end
    $display("%s: %s addr=%0d din=%08h douta=%08h", tag, we ? "WR" : "RD", a, d, douta);
    check_val(tag, douta, exp);
  endtask

  // Assert reset between edges, try a write across an edge, then release.
  task automatic reset_pulse(input string tag, input dm_addr_t a, input dm_word_t d);
    @(negedge clka);
    rsta = 1'b0;
    #1;
    $display("%s: reset asserted douta=%08h", tag, douta);
    check_val({tag, "_async"}, douta, '0);
    wea   = 1'b1;
    addra = a;
    dina  = d;
    @(posedge clka);
    #1;
    $display("%s: blocked WR addr=%0d din=%08h douta=%08h", tag, a, d, douta);
    check_val({tag, "_hold"}, douta, '0);
    @(negedge clka);
    rsta = 1'b1;
    wea  = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < DM_DEPTH; i++) model_mem[i] = '0;
    rsta  = 1'b0;
    wea   = 1'b0;
    addra = '0;
    dina  = '0;
    #1;
    check_val("reset_state", douta, '0);
    repeat (2) @(posedge clka);
    @(negedge clka);
    rsta = 1'b1;

    // Directed test plan
    do_op("powerup_read", 1'b0, 10'd1, 32'h0);
    do_op("write_first", 1'b1, 10'd2, 32'd5);
    do_op("isolation", 1'b0, 10'd4, 32'h0);
    do_op("readback", 1'b0, 10'd2, 32'h0);
    reset_pulse("reset_mid", 10'd2, 32'd9);
    do_op("retained", 1'b0, 10'd2, 32'h0);
    do_op("wr_top", 1'b1, 10'd1023, 32'hFFFF_FFFF);
    do_op("wr_bottom", 1'b1, 10'd0, 32'hA5A5_A5A5);
    do_op("rd_top", 1'b0, 10'd1023, 32'h0);
    do_op("rd_bottom", 1'b0, 10'd0, 32'h0);
    do_op("b2b_wr1", 1'b1, 10'd7, 32'h1111_2222);
    do_op("b2b_wr2", 1'b1, 10'd7, 32'h3333_4444);
    do_op("b2b_rd", 1'b0, 10'd7, 32'h0);

    // Randomized traffic, addresses biased toward a small window for reuse
    for (int n = 0; n < 400; n++) begin
      dm_addr_t a;
      logic     we;
      if ($urandom_range(0, 3) == 0) a = dm_addr_t'($urandom_range(0, DM_DEPTH - 1));
      else a = dm_addr_t'($urandom_range(0, 15));
      we = ($urandom_range(0, 2) == 0);
      do_op("rand", we, a, dm_word_t'($urandom));
      if (n == 200) reset_pulse("reset_rand", a, dm_word_t'($urandom));
    end

    // Final sweep over the hot window confirms all retained contents
    for (int i = 0; i < 16; i++) do_op("sweep", 1'b0, dm_addr_t'(i), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_data_mem
